// File: rtl/axi4lite_slave_regfile.sv
// axi4lite_slave_regfile: AXI4-Lite register file with byte strobes and flat register export.
module axi4lite_slave_regfile #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int NUM_REGS = 4
) (
  input  logic                                 S_AXI_ACLK,
  input  logic                                 S_AXI_ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]        S_AXI_AWADDR,
  input  logic [2:0]                           S_AXI_AWPROT,
  input  logic                                 S_AXI_AWVALID,
  output logic                                 S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]        S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]      S_AXI_WSTRB,
  input  logic                                 S_AXI_WVALID,
  output logic                                 S_AXI_WREADY,
  output logic [1:0]                           S_AXI_BRESP,
  output logic                                 S_AXI_BVALID,
  input  logic                                 S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]        S_AXI_ARADDR,
  input  logic [2:0]                           S_AXI_ARPROT,
  input  logic                                 S_AXI_ARVALID,
  output logic                                 S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]        S_AXI_RDATA,
  output logic [1:0]                           S_AXI_RRESP,
  output logic                                 S_AXI_RVALID,
  input  logic                                 S_AXI_RREADY,
  output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] regs_out
);
  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int AW = C_S_AXI_ADDR_WIDTH;
  localparam int NB = DW / 8;
  localparam int LSB = $clog2(NB);
  localparam int IW = AW - LSB;
  localparam logic [IW:0] NR = (IW+1)'(NUM_REGS);
  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;
  w_state_t w_state, w_state_n;
  r_state_t r_state, r_state_n;
  logic aw_cap, w_cap, aw_cap_n, w_cap_n, awready, wready, arready;
  logic aw_hs, w_hs, ar_hs, commit, b_done, r_done, aw_ok, ar_ok;
  logic [IW-1:0] aw_idx, ar_idx;
  logic [DW-1:0] wdata, rdata, rd_val;
  logic [NB-1:0] wstrb;
  logic [1:0] bresp, rresp;
  logic [DW-1:0] regs [NUM_REGS];
  logic unused;
  assign unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[LSB-1:0], S_AXI_ARADDR[LSB-1:0]};
  always_comb begin
    aw_hs = S_AXI_AWVALID & awready;
    w_hs = S_AXI_WVALID & wready;
    commit = w_state == W_IDLE && aw_cap && w_cap;
    b_done = w_state == W_RESP && S_AXI_BREADY;
    w_state_n = commit ? W_RESP : b_done ? W_IDLE : w_state;
    aw_cap_n = ~b_done & (aw_cap | aw_hs);
    w_cap_n = ~b_done & (w_cap | w_hs);
    ar_hs = S_AXI_ARVALID & arready;
    r_done = r_state == R_DATA && S_AXI_RREADY;
    r_state_n = ar_hs ? R_DATA : r_done ? R_IDLE : r_state;
    ar_idx = S_AXI_ARADDR[AW-1:LSB];
    aw_ok = {1'b0, aw_idx} < NR;
    ar_ok = {1'b0, ar_idx} < NR;
    rd_val = '0;
    for (int k = 0; k < NUM_REGS; k++)
      if (ar_idx == k[IW-1:0]) rd_val = regs[k];
  end
  // Reads sample regs before this edge's commit, so a colliding read sees the old value.
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      w_state <= W_IDLE;
      r_state <= R_IDLE;
      {aw_cap, w_cap, awready, wready, arready} <= '0;
      {aw_idx, wdata, wstrb, bresp, rdata, rresp} <= '0;
      for (int k = 0; k < NUM_REGS; k++) regs[k] <= '0;
    end else begin
      w_state <= w_state_n;
      aw_cap <= aw_cap_n;
      w_cap <= w_cap_n;
      awready <= w_state_n == W_IDLE && !aw_cap_n;
      wready <= w_state_n == W_IDLE && !w_cap_n;
      if (aw_hs) aw_idx <= S_AXI_AWADDR[AW-1:LSB];
      if (w_hs) {wdata, wstrb} <= {S_AXI_WDATA, S_AXI_WSTRB};
      if (commit) bresp <= aw_ok ? 2'b00 : 2'b10;
      for (int k = 0; k < NUM_REGS; k++)
        for (int b = 0; b < NB; b++)
          if (commit && aw_idx == k[IW-1:0] && wstrb[b]) regs[k][b*8 +: 8] <= wdata[b*8 +: 8];
      r_state <= r_state_n;
      arready <= r_state_n == R_IDLE;
      if (ar_hs) {rdata, rresp} <= {rd_val, ar_ok ? 2'b00 : 2'b10};
      else if (r_done) {rdata, rresp} <= '0;
    end
  end
  assign S_AXI_AWREADY = awready;
  assign S_AXI_WREADY = wready;
  assign S_AXI_BVALID = w_state == W_RESP;
  assign S_AXI_BRESP = bresp;
  assign S_AXI_ARREADY = arready;
  assign S_AXI_RVALID = r_state == R_DATA;
  assign S_AXI_RDATA = rdata;
  assign S_AXI_RRESP = rresp;
  for (genvar k = 0; k < NUM_REGS; k++) begin : g_out
    assign regs_out[k*DW +: DW] = regs[k];
  end
endmodule

// File: tb/tb_axi4lite_slave_regfile.sv
// tb_axi4lite_slave_regfile: scoreboard bench for the AXI4-Lite register file (3 registers).
module tb_axi4lite_slave_regfile;
  logic clk = 0, rst;
  logic [3:0] awaddr, araddr, wstrb;
  logic [31:0] wdata, rdata;
  logic [2:0] prot;
  logic awvalid, wvalid, bready, arvalid, rready;
  logic awready, wready, bvalid, arready, rvalid;
  logic [1:0] bresp, rresp;
  logic [95:0] regs_out;
  int errors = 0, checks = 0;
  logic [31:0] model [3];
  logic [1:0] bq[$];
  logic [33:0] rq[$];
  always #5 clk = ~clk;
  axi4lite_slave_regfile #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4), .NUM_REGS(3)) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESET(rst),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(prot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(prot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .regs_out(regs_out)
  );
  function automatic void model_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    int idx = int'(a[3:2]);
    if (idx < 3) for (int b = 0; b < 4; b++) if (s[b]) model[idx][b*8 +: 8] = d[b*8 +: 8];
    bq.push_back(idx < 3 ? 2'b00 : 2'b10);
  endfunction
  function automatic void model_read(input logic [3:0] a);
    int idx = int'(a[3:2]);
    if (idx < 3) rq.push_back({2'b00, model[idx]});
    else rq.push_back({2'b10, 32'h0});
  endfunction
  task automatic write_txn(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s, output logic [1:0] r);
    logic ah, wh;
    int n = 0;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1; bready = 1;
    while ((awvalid || wvalid) && n < 20) begin
      ah = awvalid && awready; wh = wvalid && wready;
      @(negedge clk); n++;
      if (ah) awvalid = 0;
      if (wh) wvalid = 0;
    end
    while (!bvalid && n < 40) begin @(negedge clk); n++; end
    if (!bvalid) begin checks++; errors++; $display("FAIL write_timeout addr=%h", a); end
    r = bresp;
    awvalid = 0; wvalid = 0;
    @(negedge clk);
  endtask
  task automatic read_txn(input logic [3:0] a, output logic [33:0] r);
    logic h;
    int n = 0;
    araddr = a; arvalid = 1; rready = 1;
    while (arvalid && n < 20) begin h = arready; @(negedge clk); n++; if (h) arvalid = 0; end
    while (!rvalid && n < 40) begin @(negedge clk); n++; end
    if (!rvalid) begin checks++; errors++; $display("FAIL read_timeout addr=%h", a); end
    r = {rresp, rdata};
    arvalid = 0;
    @(negedge clk);
  endtask
  task automatic test_reset;
    rst = 1;
    repeat (3) @(negedge clk);
    checks++; if ({awready, wready, arready, bvalid, rvalid} !== 5'b0) begin errors++; $display("FAIL reset_outputs got=%b exp=00000", {awready, wready, arready, bvalid, rvalid}); end
    checks++; if (regs_out !== 96'h0) begin errors++; $display("FAIL reset_regs got=%h exp=0", regs_out); end
    rst = 0;
    @(negedge clk);
    checks++; if ({awready, wready, arready} !== 3'b111) begin errors++; $display("FAIL reset_readies got=%b exp=111", {awready, wready, arready}); end
  endtask
  task automatic test_same_cycle;
    logic [1:0] e;
    model_write(4'h4, 32'hDEADBEEF, 4'hF);
    awaddr = 4'h4; wdata = 32'hDEADBEEF; wstrb = 4'hF; awvalid = 1; wvalid = 1; bready = 1;
    @(negedge clk);
    awvalid = 0; wvalid = 0;
    checks++; if ({bvalid, awready, wready} !== 3'b000) begin errors++; $display("FAIL same_hs got=%b exp=000", {bvalid, awready, wready}); end
    @(negedge clk);
    e = bq.pop_front();
    checks++; if (bvalid !== 1'b1 || bresp !== e) begin errors++; $display("FAIL same_bresp got=%b/%b exp=1/%b", bvalid, bresp, e); end
    checks++; if (regs_out[63:32] !== model[1]) begin errors++; $display("FAIL same_reg1 got=%h exp=%h", regs_out[63:32], model[1]); end
    @(negedge clk);
    checks++; if ({bvalid, awready, wready} !== 3'b011) begin errors++; $display("FAIL same_done got=%b exp=011", {bvalid, awready, wready}); end
  endtask
  task automatic test_w_before_aw;
    logic [1:0] e;
    model_write(4'h8, 32'h11223344, 4'hF);
    bready = 0; wdata = 32'h11223344; wstrb = 4'hF; wvalid = 1;
    @(negedge clk);
    wvalid = 0;
    checks++; if ({wready, awready} !== 2'b01) begin errors++; $display("FAIL wfirst_readies got=%b exp=01", {wready, awready}); end
    repeat (2) @(negedge clk);
    awaddr = 4'h8; awvalid = 1;
    @(negedge clk);
    awvalid = 0;
    checks++; if (bvalid !== 1'b0) begin errors++; $display("FAIL wfirst_early_b got=%b exp=0", bvalid); end
    @(negedge clk);
    e = bq.pop_front();
    checks++; if (bvalid !== 1'b1 || bresp !== e) begin errors++; $display("FAIL wfirst_bresp got=%b/%b exp=1/%b", bvalid, bresp, e); end
    checks++; if (regs_out[95:64] !== model[2]) begin errors++; $display("FAIL wfirst_reg2 got=%h exp=%h", regs_out[95:64], model[2]); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if ({bvalid, awready, wready} !== 3'b100) begin errors++; $display("FAIL wfirst_hold got=%b exp=100", {bvalid, awready, wready}); end
    end
    bready = 1;
    @(negedge clk);
    checks++; if ({bvalid, awready, wready} !== 3'b011) begin errors++; $display("FAIL wfirst_done got=%b exp=011", {bvalid, awready, wready}); end
  endtask
  task automatic test_strobe_read;
    logic [1:0] r, e;
    logic [33:0] x;
    model_write(4'h0, 32'hFFFFFFFF, 4'hF); write_txn(4'h0, 32'hFFFFFFFF, 4'hF, r);
    e = bq.pop_front(); checks++; if (r !== e) begin errors++; $display("FAIL strb_bresp0 got=%b exp=%b", r, e); end
    model_write(4'h0, 32'h000000AB, 4'b0001); write_txn(4'h0, 32'h000000AB, 4'b0001, r);
    e = bq.pop_front(); checks++; if (r !== e) begin errors++; $display("FAIL strb_bresp1 got=%b exp=%b", r, e); end
    model_read(4'h0);
    araddr = 4'h0; arvalid = 1; rready = 0;
    @(negedge clk);
    arvalid = 0;
    x = rq.pop_front();
    checks++; if (rvalid !== 1'b1 || {rresp, rdata} !== x) begin errors++; $display("FAIL strb_read got=%b/%h exp=1/%h", rvalid, {rresp, rdata}, x); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (rvalid !== 1'b1 || arready !== 1'b0 || {rresp, rdata} !== x) begin errors++; $display("FAIL strb_hold got=%b%b/%h exp=10/%h", rvalid, arready, {rresp, rdata}, x); end
    end
    rready = 1;
    @(negedge clk);
    checks++; if ({rvalid, arready} !== 2'b01 || rdata !== 32'h0) begin errors++; $display("FAIL strb_rdone got=%b/%h exp=01/0", {rvalid, arready}, rdata); end
  endtask
  task automatic test_slverr;
    logic [1:0] r, e;
    logic [33:0] x;
    model_write(4'hC, 32'h12345678, 4'hF); write_txn(4'hC, 32'h12345678, 4'hF, r);
    e = bq.pop_front(); checks++; if (r !== e) begin errors++; $display("FAIL slverr_bresp got=%b exp=%b", r, e); end
    checks++; if (regs_out !== {model[2], model[1], model[0]}) begin errors++; $display("FAIL slverr_regs got=%h exp=%h", regs_out, {model[2], model[1], model[0]}); end
    model_read(4'hC); read_txn(4'hC, x);
    e = 2'b0;
    checks++; if (x !== rq.pop_front()) begin errors++; $display("FAIL slverr_read got=%h exp=%h", x, {2'b10, 32'h0}); end
  endtask
  task automatic test_collision;
    logic [1:0] r, e;
    logic [33:0] x;
    model_write(4'h4, 32'h5, 4'hF); write_txn(4'h4, 32'h5, 4'hF, r);
    e = bq.pop_front(); checks++; if (r !== e) begin errors++; $display("FAIL coll_pre got=%b exp=%b", r, e); end
    model_read(4'h4);
    awaddr = 4'h4; wdata = 32'h9; wstrb = 4'hF; awvalid = 1; wvalid = 1; bready = 1;
    @(negedge clk);
    awvalid = 0; wvalid = 0; araddr = 4'h4; arvalid = 1; rready = 1;
    @(negedge clk);
    arvalid = 0;
    model_write(4'h4, 32'h9, 4'hF);
    x = rq.pop_front();
    checks++; if (rvalid !== 1'b1 || {rresp, rdata} !== x) begin errors++; $display("FAIL coll_old got=%b/%h exp=1/%h", rvalid, {rresp, rdata}, x); end
    e = bq.pop_front();
    checks++; if (bvalid !== 1'b1 || bresp !== e) begin errors++; $display("FAIL coll_bresp got=%b/%b exp=1/%b", bvalid, bresp, e); end
    @(negedge clk);
    model_read(4'h4); read_txn(4'h4, x);
    checks++; if (x !== rq[0]) begin errors++; $display("FAIL coll_new got=%h exp=%h", x, rq[0]); end
    void'(rq.pop_front());
  endtask
  task automatic test_reset_mid;
    logic [1:0] e;
    bready = 0; rready = 0; awaddr = 4'h0; wdata = 32'hCAFEF00D; wstrb = 4'hF; awvalid = 1; wvalid = 1; araddr = 4'h4; arvalid = 1;
    @(negedge clk);
    awvalid = 0; wvalid = 0; arvalid = 0;
    @(negedge clk);
    checks++; if ({bvalid, rvalid} !== 2'b11) begin errors++; $display("FAIL mid_pending got=%b exp=11", {bvalid, rvalid}); end
    rst = 1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) model[i] = 32'h0;
    checks++; if ({bvalid, rvalid, awready, wready, arready} !== 5'b0) begin errors++; $display("FAIL mid_drop got=%b exp=00000", {bvalid, rvalid, awready, wready, arready}); end
    checks++; if (regs_out !== 96'h0) begin errors++; $display("FAIL mid_regs got=%h exp=0", regs_out); end
    rst = 0;
    @(negedge clk);
    checks++; if ({awready, wready, arready} !== 3'b111) begin errors++; $display("FAIL mid_readies got=%b exp=111", {awready, wready, arready}); end
    awaddr = 4'h4; awvalid = 1;
    @(negedge clk);
    awvalid = 0; rst = 1;
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    bready = 1; wdata = 32'h77; wstrb = 4'hF; wvalid = 1;
    @(negedge clk);
    wvalid = 0;
    repeat (3) @(negedge clk);
    checks++; if (bvalid !== 1'b0 || regs_out !== 96'h0) begin errors++; $display("FAIL mid_partial got=%b/%h exp=0/0", bvalid, regs_out); end
    model_write(4'h4, 32'h77, 4'hF);
    awaddr = 4'h4; awvalid = 1;
    @(negedge clk);
    awvalid = 0;
    @(negedge clk);
    e = bq.pop_front();
    checks++; if (bvalid !== 1'b1 || bresp !== e || regs_out[63:32] !== model[1]) begin errors++; $display("FAIL mid_finish got=%b/%b/%h exp=1/%b/%h", bvalid, bresp, regs_out[63:32], e, model[1]); end
    @(negedge clk);
  endtask
  task automatic test_back_to_back;
    logic [1:0] r, e;
    logic [3:0] a, s;
    logic [31:0] d;
    logic [33:0] x, ex;
    for (int i = 0; i < 10; i++) begin
      a = 4'(($urandom_range(0, 3)) << 2); d = $urandom; s = (i == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      model_write(a, d, s); write_txn(a, d, s, r);
      e = bq.pop_front();
      checks++; if (r !== e) begin errors++; $display("FAIL b2b_bresp%0d got=%b exp=%b", i, r, e); end
      checks++; if (regs_out !== {model[2], model[1], model[0]}) begin errors++; $display("FAIL b2b_regs%0d got=%h exp=%h", i, regs_out, {model[2], model[1], model[0]}); end
    end
    for (int i = 0; i < 4; i++) begin
      a = 4'(i << 2);
      model_read(a); read_txn(a, x);
      ex = rq.pop_front();
      checks++; if (x !== ex) begin errors++; $display("FAIL b2b_read%0d got=%h exp=%h", i, x, ex); end
    end
    checks++; if (bq.size() != 0 || rq.size() != 0) begin errors++; $display("FAIL sb_leftover got=%0d/%0d exp=0/0", bq.size(), rq.size()); end
  endtask
  initial begin
    rst = 1; prot = 3'b0; awaddr = 0; araddr = 0; wdata = 0; wstrb = 0;
    awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
    for (int i = 0; i < 3; i++) model[i] = 32'h0;
    test_reset;
    test_same_cycle;
    test_w_before_aw;
    test_strobe_read;
    test_slverr;
    test_collision;
    test_reset_mid;
    test_back_to_back;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
endmodule

// File: doc/axi4lite_slave_regfile.md
Name: axi4lite_slave_regfile

Overview:
- AXI4-Lite slave register file; the downstream stage consuming the transactions produced by our AXI4-Lite master.
- Holds NUM_REGS word registers, writable with byte strobes and readable over the read channels.
- All register contents are exported flat for control fabric.
- Write and read paths are independent FSMs; single outstanding transaction per path.

Parameters:
C_S_AXI_DATA_WIDTH, 32, data width (32 or 64)
C_S_AXI_ADDR_WIDTH, 4, byte address width
NUM_REGS, 4, implemented registers, 1..2**(C_S_AXI_ADDR_WIDTH-log2(DATA_WIDTH/8))

Ports:
S_AXI_ACLK  in  1  clock, all logic on rising edge
S_AXI_ARESET  in  1  synchronous reset, active-high
S_AXI_AWADDR  in  ADDR_WIDTH  write byte address
S_AXI_AWPROT  in  3  ignored
S_AXI_AWVALID  in  1  write address valid
S_AXI_AWREADY  out  1  write address ready
S_AXI_WDATA  in  DATA_WIDTH  write data
S_AXI_WSTRB  in  DATA_WIDTH/8  byte enables
S_AXI_WVALID  in  1  write data valid
S_AXI_WREADY  out  1  write data ready
S_AXI_BRESP  out  2  write response
S_AXI_BVALID  out  1  write response valid
S_AXI_BREADY  in  1  write response ready
S_AXI_ARADDR  in  ADDR_WIDTH  read byte address
S_AXI_ARPROT  in  3  ignored
S_AXI_ARVALID  in  1  read address valid
S_AXI_ARREADY  out  1  read address ready
S_AXI_RDATA  out  DATA_WIDTH  read data
S_AXI_RRESP  out  2  read response
S_AXI_RVALID  out  1  read data valid
S_AXI_RREADY  in  1  read data ready
regs_out  out  NUM_REGS*DATA_WIDTH  register contents; reg k at bits [k*DW +: DW]

Behaviour:
- One clock (S_AXI_ACLK); reset S_AXI_ARESET synchronous, active-high.
- Reset: all outputs and registers 0, including AWREADY/WREADY/ARREADY. Readies rise on the first edge after reset deasserts.
- Word index = addr[ADDR_WIDTH-1:log2(DW/8)]. Low byte-offset bits are ignored.
- Write FSM states:
  - W_IDLE: AWREADY=~aw_captured, WREADY=~w_captured. A handshake on either channel latches addr/data+strb and drops that ready next cycle. AW and W may arrive in either order or in the same cycle.
  - Both captured -> W_RESP on the next edge. At that edge: commit the register byte lanes where WSTRB=1; set BVALID=1; set BRESP.
  - W_RESP: BVALID held, BRESP stable, both readies 0. On BVALID&BREADY edge: BVALID=0, clear captures, return to W_IDLE; readies high the following cycle.
  - Latency: the last of AW/W handshakes at edge N gives register update and BVALID at edge N+1.
- Read FSM states:
  - R_IDLE: ARREADY=1. On an AR handshake at edge N, at the same edge: RDATA = register value, RVALID=1, ARREADY=0, enter R_DATA.
  - R_DATA: RDATA/RRESP/RVALID stable until RVALID&RREADY. Then RVALID=0, RDATA=0, ARREADY=1 next cycle. Maximum throughput is 1 read per 2 cycles.
- Responses:
  - Index < NUM_REGS: OKAY 2'b00.
  - Index >= NUM_REGS: SLVERR 2'b10. The write is discarded; the read returns RDATA=0.
- Simultaneous events:
  - Write commit edge coinciding with an AR handshake to the same register: read returns the pre-write value.
  - Read and write paths never stall each other.
- WSTRB=0: the handshake completes with OKAY and the register is unchanged.
- Reset mid-transaction: pending BVALID/RVALID drop at the reset edge and captured AW/W are discarded. No register is written by an incomplete transaction.
- regs_out reflects the committed value from the edge after commit.
- VALID inputs dropped before handshake are not an AXI protocol case; the block need not detect them.

Test Plan:
- Reset, then AW(0x4)+W(0xDEADBEEF, strb 4'hF) same cycle, BREADY=1 -> BVALID one cycle later, BRESP=00; regs_out[63:32]=DEADBEEF.
- W(0x11223344) 3 cycles before AW(0x8), BREADY held low 4 cycles -> AWREADY/WREADY stay 0 while BVALID is held; reg2=11223344 after AW+1.
- Write 0xFFFFFFFF to reg0, then 0x000000AB with strb 4'b0001 -> read 0x0 returns FFFFFFAB, RRESP=00, RVALID held until RREADY.
- NUM_REGS=3, write/read 0xC -> BRESP=10, RRESP=10, RDATA=0, reg contents unchanged.
- Read of reg1 (old value 5) with AR handshake on the same edge as write commit of 9 -> RDATA=5; subsequent read returns 9.
- Assert reset while BVALID=1 and RVALID=1 -> both 0 next edge, all regs 0, readies 1 one edge after reset release.
